// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the NN activation blocks (forward and backward).
// Provides the default word width, fractional-bit count, leaky slope and the word typedef.
package nn_fixed_pkg;

  localparam int unsigned NN_WIDTH     = 32;
  localparam int unsigned NN_FRAC_BITS = 16;
  // About 0.01 in Q16.16; signed so it can be sign-extended to wider words
  localparam int          NN_ALPHA     = 655;

  typedef logic signed [NN_WIDTH-1:0] fx_word_t;

endpackage : nn_fixed_pkg

// File: rtl/fixed_point.sv
// Signed fixed-point arithmetic unit shared by the forward and backward activations.
// Ports:
//   a, b     : signed operands in Q(WIDTH-FRAC_BITS).FRAC_BITS
//   mul_res  : (a*b) >>> FRAC_BITS, floored, truncated to WIDTH (no saturation)
//   add_res  : a + b, wrapping
module fixed_point
  import nn_fixed_pkg::*;
#(
  parameter int unsigned WIDTH     = NN_WIDTH,
  parameter int unsigned FRAC_BITS = NN_FRAC_BITS
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] mul_res,
  output logic signed [WIDTH-1:0] add_res
);

  localparam int unsigned PW = 2 * WIDTH;

  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  logic signed [PW-1:0] w_prod;

  // Full-width signed product; the arithmetic shift floors toward -inf
  assign w_a_ext = PW'(a);
  assign w_b_ext = PW'(b);
  assign w_prod  = w_a_ext * w_b_ext;
  assign mul_res = WIDTH'(w_prod >>> FRAC_BITS);
  assign add_res = a + b;

endmodule : fixed_point

// File: rtl/leaky_relu_backward.sv
// Leaky-ReLU backward pass: joins the cached activation stream x with the upstream
// gradient stream g and emits dL/dx = g (x > 0) or (ALPHA*g) >>> FRAC_BITS (x <= 0).
// Two-stage valid/ready pipeline, one pair per cycle, vector framing via elem_idx/gi_last.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   x_valid/x_ready/x_data        : forward activation input stream
//   g_valid/g_ready/g_data        : upstream gradient input stream
//   gi_valid/gi_ready/gi_data/gi_last : gradient output stream, last marks vector end
//   elem_idx                      : index of the next element to be accepted
module leaky_relu_backward
  import nn_fixed_pkg::*;
#(
  parameter int unsigned WIDTH     = NN_WIDTH,
  parameter int unsigned FRAC_BITS = NN_FRAC_BITS,
  parameter int          ALPHA     = NN_ALPHA,
  parameter int unsigned VEC_LEN   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       x_valid,
  output logic                       x_ready,
  input  logic signed [WIDTH-1:0]    x_data,
  input  logic                       g_valid,
  output logic                       g_ready,
  input  logic signed [WIDTH-1:0]    g_data,
  output logic                       gi_valid,
  input  logic                       gi_ready,
  output logic signed [WIDTH-1:0]    gi_data,
  output logic                       gi_last,
  output logic [$clog2(VEC_LEN)-1:0] elem_idx
);

  localparam int unsigned            IDX_W    = $clog2(VEC_LEN);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic signed [WIDTH-1:0] ALPHA_W = WIDTH'(ALPHA);

  logic                    w_s1_can_accept;
  logic                    w_s2_can_accept;
  logic                    w_accept;
  logic                    w_x_pos;
  logic signed [WIDTH-1:0] w_alpha_prod;
  logic signed [WIDTH-1:0] w_add_res_unused;
  logic signed [WIDTH-1:0] w_gi_sel;

  logic                    r_s1_valid;
  logic                    r_s1_pos;
  logic                    r_s1_last;
  logic signed [WIDTH-1:0] r_s1_g;
  logic signed [WIDTH-1:0] r_s1_alpha;
  logic                    r_gi_valid;
  logic                    r_gi_last;
  logic signed [WIDTH-1:0] r_gi_data;
  logic [IDX_W-1:0]        r_idx;

  // Alpha-side product uses the same arithmetic unit as the forward path
  fixed_point #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_alpha_mul (
    .a       (g_data),
    .b       (ALPHA_W),
    .mul_res (w_alpha_prod),
    .add_res (w_add_res_unused)
  );

  // Backpressure chain and stream join; readies are held low during reset
  assign w_s2_can_accept = !r_gi_valid || gi_ready;
  assign w_s1_can_accept = !r_s1_valid || w_s2_can_accept;
  assign x_ready         = rst_n && g_valid && w_s1_can_accept;
  assign g_ready         = rst_n && x_valid && w_s1_can_accept;
  assign w_accept        = x_valid && x_ready;

  // Strictly positive: sign bit clear and not zero (zero takes the alpha path)
  assign w_x_pos  = !x_data[WIDTH-1] && (x_data != '0);
  assign w_gi_sel = r_s1_pos ? r_s1_g : r_s1_alpha;

  // Stage 1: mask, gradient, alpha product and last flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_pos   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_g     <= '0;
      r_s1_alpha <= '0;
    end else if (w_s1_can_accept) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_pos   <= w_x_pos;
        r_s1_last  <= (r_idx == LAST_IDX);
        r_s1_g     <= g_data;
        r_s1_alpha <= w_alpha_prod;
      end
    end
  end

  // Stage 2: selected result; last is cleared whenever the output slot empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gi_valid <= 1'b0;
      r_gi_last  <= 1'b0;
      r_gi_data  <= '0;
    end else if (w_s2_can_accept) begin
      r_gi_valid <= r_s1_valid;
      r_gi_last  <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        r_gi_data <= w_gi_sel;
      end
    end
  end

  // Element counter, wraps at the vector length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
    end
  end

  assign gi_valid = r_gi_valid;
  assign gi_last  = r_gi_last;
  assign gi_data  = r_gi_data;
  assign elem_idx = r_idx;

endmodule : leaky_relu_backward

// File: doc/leaky_relu_backward.md
LEAKY_RELU_BACKWARD -- requirements
Module: leaky_relu_backward

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the signed fixed-point word width.
REQ-002 SHALL have parameter FRAC_BITS, default 16, meaning the number of fractional bits.
REQ-003 SHALL have parameter ALPHA, default 655 (about 0.01 in Q16), meaning the signed negative-side slope in the same Q format.
REQ-004 SHALL have parameter VEC_LEN, default 16, meaning the elements per vector, where VEC_LEN >= 2.
REQ-005 SHALL have port clk, input, 1 bit; it is the single clock, and all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit; it is the asynchronous, active-low reset.
REQ-007 SHALL have ports x_valid / x_ready / x_data, in / out / in, widths 1 / 1 / WIDTH (signed); this stream carries the cached forward-pass activation inputs.
REQ-008 SHALL have ports g_valid / g_ready / g_data, in / out / in, widths 1 / 1 / WIDTH (signed); this stream carries the upstream gradient dL/dy.
REQ-009 SHALL have ports gi_valid / gi_ready / gi_data / gi_last, out / in / out / out, widths 1 / 1 / WIDTH (signed) / 1; this stream carries the gradient dL/dx.
REQ-010 SHALL have port elem_idx, output, clog2(VEC_LEN) bits; it is the index of the next element to be accepted.

Function
REQ-011 SHALL compute gi = g when x > 0 (strictly), and gi = (ALPHA * g) >>> FRAC_BITS otherwise.
REQ-012 SHALL form the full 2*WIDTH signed product, arithmetic-shift it right by FRAC_BITS (flooring toward negative infinity), and truncate it to WIDTH bits without saturation.
REQ-013 SHALL treat x == 0 as the alpha path.
REQ-014 SHALL join the two input streams: a pair is accepted in a cycle only if x_valid, g_valid and stage-1 acceptance are all true.
REQ-015 SHALL drive x_ready = g_valid AND s1_can_accept, and g_ready = x_valid AND s1_can_accept, so that neither stream is ever consumed alone.
REQ-016 SHALL implement a two-stage pipeline: stage 1 registers the sign mask (x > 0), g, and the alpha product; stage 2 registers the selected result as gi_data.
REQ-017 SHALL define s1_can_accept = !s1_valid OR s2_can_accept, and s2_can_accept = !gi_valid OR gi_ready.
REQ-018 SHALL have a latency of exactly 2 cycles from accept edge to gi_valid when gi_ready is held high.
REQ-019 SHALL sustain a throughput of one pair per cycle.
REQ-020 SHALL hold gi_data, gi_last and gi_valid stable while gi_valid=1 and gi_ready=0, and SHALL drop, duplicate or reorder no element under any backpressure pattern.
REQ-021 SHALL keep gi_valid asserted until a handshake occurs, and SHALL allow an output handshake and an input accept in the same cycle.
REQ-022 SHALL increment elem_idx on each accepted pair, wrapping from VEC_LEN-1 to 0.
REQ-023 SHALL mark a pair accepted at elem_idx == VEC_LEN-1 as last; the last flag SHALL travel with the data, and gi_last SHALL equal it while gi_valid = 1 and be 0 otherwise.
REQ-024 SHALL ignore x_data and g_data when no accept occurs.

Reset
REQ-025 SHALL, on rst_n low, immediately clear s1_valid, gi_valid, gi_last and elem_idx, and drive gi_data to 0.
REQ-026 SHALL discard all in-flight elements on a mid-operation reset, and SHALL restart at elem_idx 0 on release.
REQ-027 SHALL keep x_ready and g_ready at 0 while rst_n is low.

Structure
REQ-028 SHALL place the WIDTH, FRAC_BITS and ALPHA defaults and a fixed-point word typedef in the shared nn_fixed_pkg package, for common use with the forward activation.
REQ-029 SHALL instantiate the existing fixed_point sub-module (a = g, b = ALPHA, mul_res used, add_res unconnected) for the alpha product, so the rounding rule is identical to the forward path.
REQ-030 SHALL contain no FSM beyond the pipeline valid bits and the elem_idx counter.

Verification
REQ-031 SHALL cover the positive path: x = 0x00050000, g = 0x00020000, gi_ready = 1 -> gi_data = 0x00020000 exactly 2 cycles after accept.
REQ-032 SHALL cover the negative path and its zero boundary: x = 0xFFFF0000, g = 0x00010000 -> gi_data = 0x0000028F; then x = 0, g = 0xFFFF0000 -> gi_data = 0xFFFFFD71.
REQ-033 SHALL cover backpressure: stream 6 pairs while gi_ready is low for cycles 2–4 -> x_ready/g_ready deassert once both stages are full, gi_data stays stable while stalled, and all 6 results emerge in order.
REQ-034 SHALL cover an unbalanced join: x_valid = 1 with g_valid = 0 for 3 cycles -> x_ready = 0 and elem_idx unchanged; asserting g_valid then gives one accept.
REQ-035 SHALL cover framing: 17 pairs -> gi_last is 1 only on the 16th output, and elem_idx = 1 after the 17th accept.
REQ-036 SHALL cover reset mid-operation: assert rst_n low with 2 elements in flight -> gi_valid = 0 immediately; after release, the first new output follows 2 cycles after its accept with elem_idx restarted at 0.
